// File: rtl/mem_wb_pipe_reg_pkg.sv
// Shared constants for the MEM->WB pipeline register slice.
package mem_wb_pipe_reg_pkg;

    localparam logic        ENABLE       = 1'b1;
    localparam logic        DISABLE      = 1'b0;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic [4:0]  NOP_REG_ADDR = 5'd0;

endpackage

// File: rtl/mem_wb_channel_reg.sv
// One register-write channel (we/addr/data) of the MEM->WB pipeline register.
module mem_wb_channel_reg
    import mem_wb_pipe_reg_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 5,
    parameter int SUPPRESS_ZERO = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  bubble,
    input  logic                  suppress_zero,
    input  logic                  we_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data
);

    logic zero_kill;
    logic we_next;

    // Only the GPR channel treats address 0 as the hard-wired $zero register.
    assign zero_kill = (SUPPRESS_ZERO != 0) && suppress_zero && (addr_in == '0);
    assign we_next   = we_in && !zero_kill;

    always_ff @(posedge clock) begin
        if (reset || bubble) begin
            we   <= DISABLE;
            addr <= ADDR_WIDTH'(NOP_REG_ADDR);
            data <= DATA_WIDTH'(ZERO_WORD);
        end else if (load) begin
            we   <= we_next;
            addr <= addr_in;
            data <= data_in;
        end
    end

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register with stall hold, bubble, flush and $zero suppression.
// Optional retire counter enabled by defining MEM_WB_RETIRE_COUNT_EN.
module mem_wb_pipe_reg
    import mem_wb_pipe_reg_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CHANNELS   = 2,
    parameter int PC_WIDTH   = 32
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           stall_mem,
    input  logic                           stall_wb,
    input  logic                           flush,
    input  logic                           mem_valid,
    input  logic [PC_WIDTH-1:0]            mem_pc,
    input  logic [CHANNELS-1:0]            mem_we,
    input  logic [CHANNELS*ADDR_WIDTH-1:0] mem_waddr,
    input  logic [CHANNELS*DATA_WIDTH-1:0] mem_wdata,
    output logic                           wb_valid,
    output logic [PC_WIDTH-1:0]            wb_pc,
    output logic [CHANNELS-1:0]            wb_we,
    output logic [CHANNELS*ADDR_WIDTH-1:0] wb_waddr,
    output logic [CHANNELS*DATA_WIDTH-1:0] wb_wdata,
    output logic [31:0]                    retire_count
);

    typedef enum logic [1:0] {
        WB_LOAD,
        WB_BUBBLE,
        WB_HOLD
    } wb_op_e;

    wb_op_e op;
    logic   load;
    logic   bubble;

    // Flush dominates; a MEM stall with WB free drains WB into a bubble.
    always_comb begin
        op = WB_LOAD;
        if (flush)
            op = WB_BUBBLE;
        else if (stall_mem && !stall_wb)
            op = WB_BUBBLE;
        else if (stall_mem)
            op = WB_HOLD;
    end

    assign load   = (op == WB_LOAD);
    assign bubble = (op == WB_BUBBLE);

    always_ff @(posedge clock) begin
        if (reset || bubble) begin
            wb_valid <= DISABLE;
            wb_pc    <= '0;
        end else if (load) begin
            wb_valid <= mem_valid;
            wb_pc    <= mem_pc;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        mem_wb_channel_reg #(
            .DATA_WIDTH    (DATA_WIDTH),
            .ADDR_WIDTH    (ADDR_WIDTH),
            .SUPPRESS_ZERO ((g == 0) ? 1 : 0)
        ) u_ch (
            .clock         (clock),
            .reset         (reset),
            .load          (load),
            .bubble        (bubble),
            .suppress_zero (ENABLE),
            .we_in         (mem_we[g] && mem_valid),
            .addr_in       (mem_waddr[g*ADDR_WIDTH +: ADDR_WIDTH]),
            .data_in       (mem_wdata[g*DATA_WIDTH +: DATA_WIDTH]),
            .we            (wb_we[g]),
            .addr          (wb_waddr[g*ADDR_WIDTH +: ADDR_WIDTH]),
            .data          (wb_wdata[g*DATA_WIDTH +: DATA_WIDTH])
        );
    end

`ifdef MEM_WB_RETIRE_COUNT_EN
    logic [31:0] retire_q;

    always_ff @(posedge clock) begin
        if (reset)
            retire_q <= '0;
        else if (load && mem_valid)
            retire_q <= retire_q + 32'd1;
    end

    assign retire_count = retire_q;
`else
    assign retire_count = '0;
`endif

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Scoreboard bench for mem_wb_pipe_reg: driver predicts, monitor compares each cycle.
module tb_mem_wb_pipe_reg;

    logic        clock;
    logic        reset;
    logic        stall_mem;
    logic        stall_wb;
    logic        flush;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic [1:0]  mem_we;
    logic [9:0]  mem_waddr;
    logic [63:0] mem_wdata;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [1:0]  wb_we;
    logic [9:0]  wb_waddr;
    logic [63:0] wb_wdata;
    logic [31:0] retire_count;

    mem_wb_pipe_reg #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .CHANNELS   (2),
        .PC_WIDTH   (32)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .stall_mem    (stall_mem),
        .stall_wb     (stall_wb),
        .flush        (flush),
        .mem_valid    (mem_valid),
        .mem_pc       (mem_pc),
        .mem_we       (mem_we),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .wb_valid     (wb_valid),
        .wb_pc        (wb_pc),
        .wb_we        (wb_we),
        .wb_waddr     (wb_waddr),
        .wb_wdata     (wb_wdata),
        .retire_count (retire_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [1:0]  we;
        logic [9:0]  waddr;
        logic [63:0] wdata;
        logic [31:0] retire;
    } exp_t;

    exp_t exp_q[$];
    exp_t model;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: next WB contents from the current inputs and previous WB contents.
    task automatic model_step();
        if (reset) begin
            model = '{1'b0, 32'd0, 2'b00, 10'd0, 64'd0, 32'd0};
        end else if (flush || (stall_mem && !stall_wb)) begin
            model.valid = 1'b0;
            model.pc    = 32'd0;
            model.we    = 2'b00;
            model.waddr = 10'd0;
            model.wdata = 64'd0;
        end else if (!stall_mem) begin
            model.valid = mem_valid;
            model.pc    = mem_pc;
            model.we[0] = mem_valid && mem_we[0] && (mem_waddr[4:0] != 5'd0);
            model.we[1] = mem_valid && mem_we[1];
            model.waddr = mem_waddr;
            model.wdata = mem_wdata;
`ifdef MEM_WB_RETIRE_COUNT_EN
            if (mem_valid) model.retire = model.retire + 32'd1;
`endif
        end
    endtask

    task automatic drive(input logic rst, input logic sm, input logic sw, input logic fl,
                         input logic v, input logic [31:0] pc, input logic [1:0] we,
                         input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1);
        reset     = rst;
        stall_mem = sm;
        stall_wb  = sw;
        flush     = fl;
        mem_valid = v;
        mem_pc    = pc;
        mem_we    = we;
        mem_waddr = {a1, a0};
        mem_wdata = {d1, d0};
        if (sw && !sm && !rst)
            $display("note: illegal stall_wb without stall_mem driven at t=%0t", $time);
        model_step();
        exp_q.push_back(model);
        @(negedge clock);
    endtask

    // Monitor: compares the registered outputs just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wb_valid", 64'(wb_valid), 64'(e.valid));
                check("wb_pc", 64'(wb_pc), 64'(e.pc));
                check("wb_we", 64'(wb_we), 64'(e.we));
                check("wb_waddr", 64'(wb_waddr), 64'(e.waddr));
                check("wb_wdata", wb_wdata, e.wdata);
                check("retire_count", 64'(retire_count), 64'(e.retire));
            end
        end
    end

    initial begin
        logic        sm;
        logic        sw;
        logic [4:0]  a0;
        model = '{1'b0, 32'd0, 2'b00, 10'd0, 64'd0, 32'd0};

        // Reset with garbage inputs for two edges.
        drive(1, 1, 0, 1, 1, 32'hA5A5_0000, 2'b11, 5'd9, 32'hBAD0_BAD0, 5'd3, 32'h1111_2222);
        drive(1, 0, 1, 0, 1, 32'h5A5A_0000, 2'b11, 5'd17, 32'hCAFE_F00D, 5'd1, 32'h3333_4444);

        // Pass-through on both channels.
        drive(0, 0, 0, 0, 1, 32'h0000_0100, 2'b11, 5'd5, 32'hDEAD_BEEF, 5'd1, 32'h1234_5678);

        // $zero suppression on ch0 only; ch1 address 0 (HI) still writes.
        drive(0, 0, 0, 0, 1, 32'h0000_0104, 2'b11, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'h0BAD_F00D);

        // Invalid capture: addr/data captured, enables cleared.
        drive(0, 0, 0, 0, 0, 32'h0000_0108, 2'b11, 5'd12, 32'h0102_0304, 5'd1, 32'h0506_0708);

        // Capture addr 7, hold across three full stalls, then drain into a bubble.
        drive(0, 0, 0, 0, 1, 32'h0000_010C, 2'b01, 5'd7, 32'h7777_7777, 5'd0, 32'h0);
        for (int unsigned i = 0; i < 3; i++)
            drive(0, 1, 1, 0, 1, 32'h0000_0200 + i, 2'b11, 5'(i + 20), $urandom, 5'd1, $urandom);
        drive(0, 1, 0, 0, 1, 32'h0000_0300, 2'b11, 5'd8, 32'h8888_8888, 5'd1, 32'h9999_9999);

        // Flush beats a full stall.
        drive(0, 0, 0, 0, 1, 32'h0000_0400, 2'b11, 5'd9, 32'h4444_0000, 5'd1, 32'h4444_1111);
        drive(0, 1, 1, 1, 1, 32'h0000_0404, 2'b11, 5'd10, 32'h5555_0000, 5'd0, 32'h5555_1111);

        // Reset during a hold discards the held state.
        drive(0, 0, 0, 0, 1, 32'h0000_0500, 2'b11, 5'd11, 32'h6666_0000, 5'd1, 32'h6666_1111);
        drive(0, 1, 1, 0, 1, 32'h0000_0504, 2'b11, 5'd12, 32'h6666_2222, 5'd1, 32'h6666_3333);
        drive(1, 1, 1, 0, 1, 32'h0000_0508, 2'b11, 5'd13, 32'h6666_4444, 5'd1, 32'h6666_5555);

`ifdef MEM_WB_RETIRE_COUNT_EN
        // Counter wrap from all-ones.
        force dut.retire_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_q;
        model.retire = 32'hFFFF_FFFF;
        drive(0, 0, 0, 0, 1, 32'h0000_0600, 2'b10, 5'd1, 32'h1, 5'd1, 32'h2);
`endif

        // Randomised traffic (never the illegal stall_wb-only combination).
        for (int unsigned i = 0; i < 400; i++) begin
            sm = ($urandom_range(3, 0) == 0);
            sw = sm && $urandom_range(1, 0);
            a0 = ($urandom_range(3, 0) == 0) ? 5'd0 : 5'($urandom);
            drive(($urandom_range(49, 0) == 0), sm, sw, ($urandom_range(9, 0) == 0),
                  ($urandom_range(3, 0) != 0), $urandom, 2'($urandom), a0, $urandom,
                  5'($urandom_range(1, 0)), $urandom);
        end

        @(posedge clock);
        #2;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got t=%0t required < 200000", $time);
        $fatal(1, "timeout");
    end

endmodule
